// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for an 8-bit datapath with an external ALU.
// Holds a 4x8 register file, the C/Z/N flags and a bounded-wait program fetch port.
module alu_sequencer #(
  parameter logic [7:0]  PC_RESET   = 8'h00,
  parameter int unsigned WAIT_LIMIT = 32'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags_q,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_EXECUTE   = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic        c_q, c_d, z_q, z_d, n_q, n_d;
  logic [31:0] wait_q, wait_d;
  logic        error_q, error_d, illegal_q, illegal_d;
  logic        mem_req_q, mem_req_d, busy_q, busy_d, halted_q, halted_d;
  logic [7:0]  alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [3:0]  alu_op_q, alu_op_d;

  logic [3:0]  op_s;
  logic [1:0]  rs_s, rd_s;
  logic        imm_form_s, logic_op_s, timeout_s;
  logic [7:0]  opx_s, opy_s, res_s;
  logic        unused_s;

  assign op_s       = ir_q[7:4];
  assign rs_s       = ir_q[3:2];
  assign rd_s       = ir_q[1:0];
  assign imm_form_s = op_s[0] & (op_s <= 4'hB);
  assign logic_op_s = (op_s >= 4'h4) & (op_s <= 4'hB);
  assign timeout_s  = (WAIT_LIMIT != 32'd0) && ((wait_q + 32'd1) == WAIT_LIMIT);
  // Operands are captured on entry to EXECUTE; for immediate forms the imm byte is on mem_rdata then.
  assign opy_s      = imm_form_s ? mem_rdata : regs_q[rs_s];
  assign opx_s      = (op_s == 4'h4) ? regs_q[rs_s] :
                      (op_s == 4'h5) ? mem_rdata : regs_q[rd_s];
  assign res_s      = alu_out[7:0];
  assign unused_s   = ^{alu_out[15:8], alu_flags[3], alu_flags[1]};

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    error_d   = error_q;
    illegal_d = illegal_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH, S_FETCH_IMM: begin
        if (mem_ready) begin
          wait_d = 32'd0;
          pc_d   = pc_q + 8'd1;
          if (state_q == S_FETCH) begin
            ir_d    = mem_rdata;
            state_d = S_DECODE;
          end else begin
            state_d = S_EXECUTE;
          end
        end else if (timeout_s) begin
          wait_d  = 32'd0;
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (imm_form_s) begin
          state_d = S_FETCH_IMM;
        end else if (op_s == 4'hD) begin
          state_d = S_HALT;
        end else if (op_s >= 4'hC) begin
          illegal_d = illegal_q | (op_s >= 4'hE);
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        regs_d[rd_s] = res_s;
        c_d          = alu_flags[0] & ~logic_op_s;
        n_d          = alu_flags[2];
        z_d          = (res_s == 8'h00);
        state_d      = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_EXECUTE) begin
      alu_op_d = op_s;
      alu_x_d  = opx_s;
      alu_y_d  = opy_s;
    end else begin
      alu_op_d = alu_op_q;
      alu_x_d  = alu_x_q;
      alu_y_d  = alu_y_q;
    end
    mem_req_d = (state_d == S_FETCH) || (state_d == S_FETCH_IMM);
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d  = (state_d == S_HALT);
  end

  // State and architectural registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      ir_q      <= 8'h00;
      wait_q    <= 32'd0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      error_q   <= 1'b0;
      illegal_q <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      alu_x_q   <= 8'h00;
      alu_y_q   <= 8'h00;
      alu_op_q  <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      error_q   <= error_d;
      illegal_q <= illegal_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_op_q  <= alu_op_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_op   = alu_op_q;
  assign flags_q  = {1'b0, n_q, z_q, c_q};
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign error    = error_q;
  assign illegal  = illegal_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against an instruction-level reference model.
// Two instances: one at PC 00 with a short fetch timeout, one at PC FE with the timeout disabled.
module tb_alu_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start_a, start_w, ready, use_w;
  logic [1:0] dbg_sel;
  logic [7:0] mem [256];

  logic        req_a, busy_a, halted_a, error_a, illegal_a;
  logic [7:0]  addr_a, rdata_a, x_a, y_a, pc_a, dbg_a;
  logic [3:0]  op_a, aflg_a, flg_a;
  logic [15:0] aout_a;
  logic        req_w, busy_w, halted_w, error_w, illegal_w;
  logic [7:0]  addr_w, rdata_w, x_w, y_w, pc_w, dbg_w;
  logic [3:0]  op_w, aflg_w, flg_w;
  logic [15:0] aout_w;

  // Stand-in ALU; junk in unused bits, and carry forced high on logic ops.
  function automatic logic [19:0] alu_fn(input logic [7:0] x, input logic [7:0] y, input logic [3:0] op);
    logic [8:0] t;
    logic [7:0] r;
    logic       c;
    t = 9'h000;
    case (op[3:1])
      3'd0: begin t = {1'b0, x} + {1'b0, y}; r = t[7:0]; c = t[8]; end
      3'd1: begin t = {1'b0, x} - {1'b0, y}; r = t[7:0]; c = t[8]; end
      3'd2: begin r = ~x;    c = 1'b1; end
      3'd3: begin r = x & y; c = 1'b1; end
      3'd4: begin r = x | y; c = 1'b1; end
      3'd5: begin r = x ^ y; c = 1'b1; end
      default: begin r = x; c = 1'b1; end
    endcase
    return {1'b1, r[7], 1'b1, c, x ^ y, r};
  endfunction

  assign rdata_a = ready ? mem[addr_a] : (8'hA5 ^ addr_a);
  assign rdata_w = ready ? mem[addr_w] : (8'hA5 ^ addr_w);
  assign {aflg_a, aout_a} = alu_fn(x_a, y_a, op_a);
  assign {aflg_w, aout_w} = alu_fn(x_w, y_w, op_w);

  alu_sequencer #(.PC_RESET(8'h00), .WAIT_LIMIT(32'd4)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mem_req(req_a), .mem_addr(addr_a),
    .mem_rdata(rdata_a), .mem_ready(ready), .alu_x(x_a), .alu_y(y_a), .alu_op(op_a),
    .alu_out(aout_a), .alu_flags(aflg_a), .flags_q(flg_a), .pc(pc_a), .busy(busy_a),
    .halted(halted_a), .error(error_a), .illegal(illegal_a), .dbg_sel(dbg_sel), .dbg_data(dbg_a));

  alu_sequencer #(.PC_RESET(8'hFE), .WAIT_LIMIT(32'd0)) dut_w (
    .clock(clock), .reset(reset), .start(start_w), .mem_req(req_w), .mem_addr(addr_w),
    .mem_rdata(rdata_w), .mem_ready(ready), .alu_x(x_w), .alu_y(y_w), .alu_op(op_w),
    .alu_out(aout_w), .alu_flags(aflg_w), .flags_q(flg_w), .pc(pc_w), .busy(busy_w),
    .halted(halted_w), .error(error_w), .illegal(illegal_w), .dbg_sel(dbg_sel), .dbg_data(dbg_w));

  logic       o_req, o_busy, o_halted, o_error, o_illegal;
  logic [7:0] o_addr, o_pc, o_dbg;
  logic [3:0] o_flg;
  assign o_req     = use_w ? req_w     : req_a;
  assign o_busy    = use_w ? busy_w    : busy_a;
  assign o_halted  = use_w ? halted_w  : halted_a;
  assign o_error   = use_w ? error_w   : error_a;
  assign o_illegal = use_w ? illegal_w : illegal_a;
  assign o_addr    = use_w ? addr_w    : addr_a;
  assign o_pc      = use_w ? pc_w      : pc_a;
  assign o_dbg     = use_w ? dbg_w     : dbg_a;
  assign o_flg     = use_w ? flg_w     : flg_a;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: interprets the program in mem as an instruction set.
  logic [7:0] exp_r [4];
  logic       exp_c, exp_z, exp_n, exp_ill;
  logic [7:0] exp_pc;
  int         exp_base;
  logic [7:0] exp_addr_q [$];

  task automatic model_run(input logic [7:0] start_pc);
    logic [7:0] p, b0, src, a, res;
    int op, tmp;
    p = start_pc;
    for (int i = 0; i < 4; i++) exp_r[i] = 8'h00;
    exp_c = 1'b0; exp_z = 1'b0; exp_n = 1'b0; exp_ill = 1'b0;
    exp_base = 0;
    exp_addr_q.delete();
    for (int step = 0; step < 300; step++) begin
      b0 = mem[p];
      exp_addr_q.push_back(p);
      p = p + 8'd1;
      op = int'(b0[7:4]);
      if (op == 13) begin exp_base += 2; break; end
      if (op >= 12) begin
        exp_base += 2;
        if (op >= 14) exp_ill = 1'b1;
        continue;
      end
      a = exp_r[b0[1:0]];
      if (op % 2 == 1) begin
        src = mem[p]; exp_addr_q.push_back(p); p = p + 8'd1; exp_base += 4;
      end else begin
        src = exp_r[b0[3:2]]; exp_base += 3;
      end
      tmp = 0;
      case (op / 2)
        0: begin tmp = int'(a) + int'(src); res = tmp[7:0]; exp_c = (tmp > 255); end
        1: begin tmp = int'(a) - int'(src); res = tmp[7:0]; exp_c = (tmp < 0); end
        2: begin res = ~src;    exp_c = 1'b0; end
        3: begin res = a & src; exp_c = 1'b0; end
        4: begin res = a | src; exp_c = 1'b0; end
        default: begin res = a ^ src; exp_c = 1'b0; end
      endcase
      exp_r[b0[1:0]] = res;
      exp_z = (res == 8'h00);
      exp_n = res[7];
    end
    exp_pc = p;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; start_a = 1'b0; start_w = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hD0;
  endtask

  task automatic run_prog(input bit w, input bit rand_wait, input string tag);
    int cycles, waits, waits_left;
    bit done;
    logic [7:0] ea;
    use_w = w;
    model_run(w ? 8'hFE : 8'h00);
    do_reset();
    waits = 0;
    waits_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
    @(negedge clock);
    if (w) start_w = 1'b1; else start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0; start_w = 1'b0;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 600) begin
      if (o_req) begin
        if (waits_left > 0) begin
          ready = 1'b0; waits_left--; waits++;
        end else begin
          ready = 1'b1;
          ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 8'h00;
          check_val({tag, "_addr"}, 32'(o_addr), 32'(ea));
          waits_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        ready = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clock);
      #1;
      cycles++;
      if (o_halted) done = 1'b1;
      else @(negedge clock);
    end
    ready = 1'b0;
    check_val({tag, "_halted"}, 32'(done), 32'd1);
    check_val({tag, "_cycles"}, 32'(cycles), 32'(exp_base + waits));
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check_val($sformatf("%s_r%0d", tag, i), 32'(o_dbg), 32'(exp_r[i]));
    end
    check_val({tag, "_flags"},   32'(o_flg),     32'({1'b0, exp_n, exp_z, exp_c}));
    check_val({tag, "_pc"},      32'(o_pc),      32'(exp_pc));
    check_val({tag, "_illegal"}, 32'(o_illegal), 32'(exp_ill));
    check_val({tag, "_error"},   32'(o_error),   32'd0);
    check_val({tag, "_busy"},    32'(o_busy),    32'd0);
    check_val({tag, "_memreq"},  32'(o_req),     32'd0);
  endtask

  initial begin
    int p, op, req_seen;
    reset = 1'b0; start_a = 1'b0; start_w = 1'b0; ready = 1'b0; use_w = 1'b0; dbg_sel = 2'd0;
    fill_halt();

    // Reset mid-fetch after one instruction has completed.
    mem[0] = 8'h10; mem[1] = 8'h5A; mem[2] = 8'h10; mem[3] = 8'h01;
    do_reset();
    @(negedge clock); start_a = 1'b1; ready = 1'b1;
    @(posedge clock);
    @(negedge clock); start_a = 1'b0;
    repeat (4) @(posedge clock);
    #1 ready = 1'b0;
    dbg_sel = 2'd0;
    #1;
    check_val("pre_rst_req", 32'(req_a), 32'd1);
    check_val("pre_rst_pc",  32'(pc_a),  32'h02);
    check_val("pre_rst_r0",  32'(dbg_a), 32'h5A);
    reset = 1'b0;
    #1;
    check_val("rst_req",   32'(req_a),   32'd0);
    check_val("rst_pc",    32'(pc_a),    32'h00);
    check_val("rst_state", 32'({busy_a, halted_a, error_a, illegal_a}), 32'd0);
    check_val("rst_flags", 32'(flg_a),   32'd0);
    check_val("rst_alu",   32'({x_a, y_a, op_a}), 32'd0);
    check_val("rst_r0",    32'(dbg_a),   32'd0);
    @(negedge clock); reset = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ready = 1'($urandom_range(0, 1));
      if (req_a || busy_a) req_seen++;
    end
    ready = 1'b0;
    check_val("idle_no_req", 32'(req_seen), 32'd0);

    // Directed programs from PC 00.
    fill_halt();
    mem[0] = 8'h10; mem[1] = 8'hFF;
    run_prog(1'b0, 1'b0, "smi_neg");
    mem[2] = 8'h10; mem[3] = 8'h01; mem[4] = 8'hD0;
    run_prog(1'b0, 1'b0, "smi_carry");
    fill_halt();
    mem[0] = 8'h11; mem[1] = 8'h0F; mem[2] = 8'h12; mem[3] = 8'h3C;
    mem[4] = 8'hA6; mem[5] = 8'h26;
    run_prog(1'b0, 1'b0, "regops");
    fill_halt();
    mem[0] = 8'h30; mem[1] = 8'h01;
    run_prog(1'b0, 1'b0, "borrow");
    fill_halt();
    mem[0] = 8'h13; mem[1] = 8'h80; mem[2] = 8'hC0; mem[3] = 8'hF0; mem[4] = 8'h5D; mem[5] = 8'h00;
    run_prog(1'b0, 1'b1, "nop_keep");

    // Randomized programs with random wait states and stray ready pulses.
    for (int t = 0; t < 6; t++) begin
      fill_halt();
      p = 0;
      for (int k = 0; k < 12; k++) begin
        op = int'($urandom_range(0, 15));
        if (op == 13) op = 2;
        mem[p] = {4'(op), 4'($urandom_range(0, 15))};
        p++;
        if ((op % 2 == 1) && (op <= 11)) begin
          mem[p] = 8'($urandom_range(0, 255));
          p++;
        end
      end
      run_prog(1'b0, 1'b1, $sformatf("rand%0d", t));
    end

    // Fetch timeout on the WAIT_LIMIT=4 instance.
    fill_halt();
    use_w = 1'b0;
    do_reset();
    @(negedge clock); start_a = 1'b1; ready = 1'b0;
    @(posedge clock);
    @(negedge clock); start_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      check_val($sformatf("to_halted_%0d", k), 32'(halted_a), 32'(k == 4));
      check_val($sformatf("to_req_%0d", k),    32'(req_a),    32'(k < 4));
    end
    check_val("to_error", 32'(error_a), 32'd1);
    check_val("to_busy",  32'(busy_a),  32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      ready = ~ready; start_a = ~start_a;
    end
    @(negedge clock); ready = 1'b0; start_a = 1'b0;
    @(negedge clock);
    check_val("to_after_pc",    32'(pc_a), 32'h00);
    check_val("to_after_state", 32'({halted_a, error_a, req_a, busy_a}), 32'b1100);

    // Timeout disabled on the WAIT_LIMIT=0 instance.
    use_w = 1'b1;
    do_reset();
    @(negedge clock); start_w = 1'b1; ready = 1'b0;
    @(posedge clock);
    @(negedge clock); start_w = 1'b0;
    repeat (20) @(negedge clock);
    check_val("nolimit_state", 32'({halted_w, error_w, req_w, busy_w}), 32'b0011);

    // PC wrap from FE, illegal opcodes, immediate fetched across the wrap.
    fill_halt();
    mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'hD0;
    run_prog(1'b1, 1'b0, "wrap_ill");
    fill_halt();
    mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'h10; mem[8'h00] = 8'h80; mem[8'h01] = 8'hF5;
    run_prog(1'b1, 1'b1, "wrap_imm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
